// File: rtl/b2_rr_arb_3_1_pkg.sv
// Shared constants and helpers for the 3-source round-robin arbiter.
package b2_rr_arb_3_1_pkg;

    // Select encoding shared with the downstream 3:1 mux.
    localparam logic [1:0] SEL_D0 = 2'b00;
    localparam logic [1:0] SEL_D1 = 2'b01;
    localparam logic [1:0] SEL_D2 = 2'b10;

    localparam int unsigned PTR_W  = 2;
    localparam int unsigned NUM_SRC = 3;

    // Modulo-3 add of two source indices (inputs assumed in 0..2).
    function automatic logic [PTR_W-1:0] mod3_add(input logic [PTR_W-1:0] a,
                                                  input logic [PTR_W-1:0] b);
        logic [PTR_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[PTR_W-1:0];
    endfunction

endpackage

// File: rtl/b2_rr_arb_3_1_rr3_grant.sv
// Combinational round-robin grant: first valid source at or after ptr.
module rr3_grant
    import b2_rr_arb_3_1_pkg::*;
(
    input  logic [NUM_SRC-1:0] in_valid,
    input  logic [PTR_W-1:0]   ptr,
    input  logic               free,
    output logic [NUM_SRC-1:0] gnt_onehot,
    output logic [PTR_W-1:0]   gnt_idx
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Scan ptr, ptr+1, ptr+2 (mod 3) and grant the first requester.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = SEL_D0;
        found      = 1'b0;
        idx        = '0;
        if (free) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                idx = mod3_add(ptr, PTR_W'(k));
                if (!found && in_valid[idx]) begin
                    found           = 1'b1;
                    gnt_onehot[idx] = 1'b1;
                    gnt_idx         = idx;
                end
            end
        end
    end

endmodule

// File: rtl/b2_rr_arb_3_1.sv
// Three-source round-robin arbiter with a single registered output slot.
module b2_rr_arb_3_1
    import b2_rr_arb_3_1_pkg::*;
#(
    parameter int unsigned W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] in_valid,
    output logic [NUM_SRC-1:0] in_ready,
    input  logic [W-1:0]       d0,
    input  logic [W-1:0]       d1,
    input  logic [W-1:0]       d2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_data,
    output logic [1:0]         out_src
);

    logic [PTR_W-1:0]   ptr;
    logic               free;
    logic [NUM_SRC-1:0] gnt_onehot;
    logic [PTR_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic [W-1:0]       sel_data;

    assign free     = !out_valid || out_ready;
    assign gnt_any  = |gnt_onehot;
    assign in_ready = gnt_onehot;

    rr3_grant u_grant (
        .in_valid   (in_valid),
        .ptr        (ptr),
        .free       (free),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx)
    );

    // Data select for the granted source.
    always_comb begin
        sel_data = d0;
        case (gnt_idx)
            SEL_D1:  sel_data = d1;
            SEL_D2:  sel_data = d2;
            default: sel_data = d0;
        endcase
    end

    // Output slot and priority pointer; accept wins over drain on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= SEL_D0;
            ptr       <= '0;
        end else if (gnt_any) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_src   <= gnt_idx;
            ptr       <= mod3_add(gnt_idx, PTR_W'(1));
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_b2_rr_arb_3_1.sv
// Self-checking bench: directed plan plus random traffic against a slot/pointer model.
module tb_b2_rr_arb_3_1;

    localparam int unsigned W = 2;

    logic         clk;
    logic         rst_n;
    logic [2:0]   in_valid;
    logic [2:0]   in_ready;
    logic [W-1:0] d0, d1, d2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   out_src;

    int checks;
    int failures;

    // Reference model state
    bit m_valid;
    int m_data;
    int m_src;
    int m_ptr;

    b2_rr_arb_3_1 #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 0;
        m_src   = 0;
        m_ptr   = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".out_src"},   32'(out_src),   32'(m_src));
        chk({tag, ".out_data"},  32'(out_data),  32'(m_data));
    endtask

    // One cycle: drive just after the edge, check in_ready, advance model at the edge, check slot.
    task automatic step(input string tag, input logic [2:0] v,
                        input int a, input int b, input int c, input logic ordy);
        int  dv[3];
        int  g;
        bit  free;
        in_valid  = v;
        d0        = W'(a);
        d1        = W'(b);
        d2        = W'(c);
        out_ready = ordy;
        dv[0] = a; dv[1] = b; dv[2] = c;
        #2;
        free = !m_valid || ordy;
        g = -1;
        if (free) begin
            for (int k = 0; k < 3; k++) begin
                if (g < 0 && v[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
            end
        end
        chk({tag, ".in_ready"}, 32'(in_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        @(posedge clk);
        if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = dv[g];
            m_src   = g;
            m_ptr   = (g + 1) % 3;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = '0;
        d0 = '0; d1 = '0; d2 = '0;
        out_ready = 1'b0;
        model_reset();
        #1;
        check_outputs("reset0");
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_outputs("idle");

        // First grant after reset goes to source 0
        step("first", 3'b111, 1, 2, 3, 1'b1);
        // Round-robin sequence 1,2,0,1,2 continues
        for (int i = 0; i < 6; i++) step("rr", 3'b111, 1, 2, 3, 1'b1);

        // Asynchronous reset mid-cycle while slot is full
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single source
        for (int i = 0; i < 4; i++) step("single", 3'b010, 0, 3, 0, 1'b1);
        // ptr=2: order 2,0,1 with only 0 and 1 valid -> source 0
        step("wrap", 3'b011, 1, 2, 3, 1'b1);

        // Load source 1 then backpressure
        step("bp_load", 3'b010, 1, 2, 3, 1'b1);
        for (int i = 0; i < 3; i++) step("bp_hold", 3'b111, 0, 1, 2, 1'b0);
        step("bp_release", 3'b111, 1, 2, 3, 1'b1);

        // Drain to empty then single request from source 2
        step("drain", 3'b000, 0, 0, 0, 1'b1);
        step("drain_idle", 3'b000, 1, 1, 1, 1'b1);
        step("after_drain", 3'b100, 0, 0, 2, 1'b1);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step("rand", 3'($urandom_range(0, 7)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
